irq_ctrl: RTL

Memory-mapped interrupt front end that sits directly upstream of the processor core's `interrupts[7:0]` input. It synchronizes eight asynchronous external request lines and detects edges or levels per line. It latches edge requests into a pending register until software clears them with a store, and drives the masked pending vector to the core. It snoops the core's data-memory write bus (`memwrite`/`dataadr`/`writedata`) for its own register window and returns read data for loads in that window.

---
 rtl/irq_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt front end: synchronizes request lines, latches edges or tracks levels,
// and exposes PENDING/MASK/MODE/OVERRUN through a snooped 16-byte store/load window.
module irq_ctrl #(
  parameter int          N    = 8,
  parameter logic [31:0] BASE = 32'h1fff0000
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic [N-1:0]  irq_in,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          hit,
  output logic [31:0]   readdata,
  output logic [N-1:0]  interrupts
);

  localparam logic [1:0] OFF_PENDING = 2'd0;
  localparam logic [1:0] OFF_MASK    = 2'd1;
  localparam logic [1:0] OFF_MODE    = 2'd2;
  localparam logic [1:0] OFF_OVERRUN = 2'd3;

  logic [N-1:0] s1_q, s2_q, prev_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] mode_q, mode_d;
  logic [N-1:0] overrun_q, overrun_d;

  logic         wr;
  logic [1:0]   off;
  logic [N-1:0] wd;
  logic [N-1:0] rise;
  logic [N-1:0] clr_pend;
  logic [N-1:0] clr_ovr;
  logic [N-1:0] rd_sel;

  // Bus snoop: a store lands on the rising edge where memwrite and hit are both high;
  // loads are answered combinationally from the current (pre-store) register state.
  assign hit        = (dataadr[31:4] == BASE[31:4]);
  assign off        = dataadr[3:2];
  assign wr         = memwrite & hit;
  assign wd         = writedata[N-1:0];
  assign rise       = s2_q & ~prev_q;
  assign interrupts = pending_q & mask_q;

  always_comb begin
    clr_pend = '0;
    clr_ovr  = '0;
    mask_d   = mask_q;
    mode_d   = mode_q;
    if (wr) begin
      case (off)
        OFF_PENDING: clr_pend = wd;
        OFF_MASK:    mask_d   = wd;
        OFF_MODE:    mode_d   = wd;
        default:     clr_ovr  = wd;
      endcase
    end
    // Edge lines: set beats clear. Level lines simply mirror the synchronized input.
    pending_d = (mode_q & ((pending_q & ~clr_pend) | rise)) | (~mode_q & s2_q);
    overrun_d = (overrun_q & ~clr_ovr) | (mode_q & rise & pending_q & ~clr_pend);
  end

  always_comb begin
    rd_sel = '0;
    case (off)
      OFF_PENDING: rd_sel = pending_q;
      OFF_MASK:    rd_sel = mask_q;
      OFF_MODE:    rd_sel = mode_q;
      OFF_OVERRUN: rd_sel = overrun_q;
      default:     rd_sel = '0;
    endcase
    readdata = '0;
    if (hit) readdata[N-1:0] = rd_sel;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '1;
      overrun_q <= '0;
    end else begin
      s1_q      <= irq_in;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
